// File: rtl/dest_pop_arbiter_if.sv
// Bus between the destination FIFOs, the pop arbiter and the output stage.
// The master modport is the FIFO/output-stage side, and the slave modport is the arbiter.
interface dest_pop_arbiter_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 16
);
  logic              arb_en;
  logic              fifo0_empty;
  logic              fifo1_empty;
  logic [DATA_W-1:0] datain_dest0;
  logic [DATA_W-1:0] datain_dest1;
  logic              out_almost_full;
  logic              pop0;
  logic              pop1;
  logic [DATA_W-1:0] dataout_dest;
  logic              validoutdest;
  logic [1:0]        arb_state;
  logic [CNT_W-1:0]  gnt0_cnt;
  logic [CNT_W-1:0]  gnt1_cnt;

  modport master (
    output arb_en, fifo0_empty, fifo1_empty, datain_dest0, datain_dest1, out_almost_full,
    input  pop0, pop1, dataout_dest, validoutdest, arb_state, gnt0_cnt, gnt1_cnt
  );

  modport slave (
    input  arb_en, fifo0_empty, fifo1_empty, datain_dest0, datain_dest1, out_almost_full,
    output pop0, pop1, dataout_dest, validoutdest, arb_state, gnt0_cnt, gnt1_cnt
  );
endinterface

// File: rtl/dest_pop_arbiter.sv
// Pop scheduler for the dest0/dest1 show-ahead FIFOs. dest0 has priority, and a starvation guard protects dest1.
// The selected word, its valid and the grant counters are registered.
module dest_pop_arbiter #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  dest_pop_arbiter_if.slave  bus
);

  localparam int unsigned SW = (MAX_STARVE == 0) ? 1 : $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  gnt0_q, gnt0_d;
  logic [CNT_W-1:0]  gnt1_q, gnt1_d;

  logic starve_due;
  logic can_pop;
  logic gnt0, gnt1;
  logic pop0, pop1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      gnt0_q   <= '0;
      gnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
    end
  end

  // Dropping the enable returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!bus.arb_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (bus.out_almost_full) state_d = STALL;
        STALL:   if (!bus.out_almost_full) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // The guard never fires when MAX_STARVE is 0. In that case, dest0 has plain fixed priority.
  assign starve_due = (MAX_STARVE != 0) && (starve_q == SW'(MAX_STARVE));
  assign can_pop    = (state_q == RUN) && bus.arb_en && !bus.out_almost_full && !reset;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!bus.fifo0_empty && !bus.fifo1_empty) begin
      gnt1 = starve_due;
      gnt0 = !starve_due;
    end else begin
      gnt0 = !bus.fifo0_empty;
      gnt1 = !bus.fifo1_empty;
    end
  end

  assign pop0 = gnt0 && can_pop;
  assign pop1 = gnt1 && can_pop;

  // Starvation tracking, output capture and saturating grant counters.
  always_comb begin
    starve_d = starve_q;
    data_d   = '0;
    valid_d  = pop0 || pop1;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;

    if (bus.fifo1_empty || pop1) begin
      starve_d = '0;
    end else if (pop0 && (starve_q != SW'(MAX_STARVE))) begin
      starve_d = starve_q + SW'(1);
    end

    if (pop1) begin
      data_d = bus.datain_dest1;
    end else if (pop0) begin
      data_d = bus.datain_dest0;
    end

    if (pop0 && (gnt0_q != '1)) gnt0_d = gnt0_q + CNT_W'(1);
    if (pop1 && (gnt1_q != '1)) gnt1_d = gnt1_q + CNT_W'(1);
  end

  assign bus.pop0         = pop0;
  assign bus.pop1         = pop1;
  assign bus.dataout_dest = data_q;
  assign bus.validoutdest = valid_q;
  assign bus.arb_state    = state_q;
  assign bus.gnt0_cnt     = gnt0_q;
  assign bus.gnt1_cnt     = gnt1_q;

endmodule

// File: tb/tb_dest_pop_arbiter.sv
// Randomized and directed bench for dest_pop_arbiter (MAX_STARVE=4 and MAX_STARVE=0 instances).
// The bench emulates both FIFOs with queues and checks the DUTs against a cycle-level reference model.
module tb_dest_pop_arbiter;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  logic en, af;
  logic              emp [2][2];
  logic [DATA_W-1:0] hd  [2][2];

  logic              o_pop0 [2];
  logic              o_pop1 [2];
  logic              o_valid[2];
  logic [DATA_W-1:0] o_data [2];
  logic [1:0]        o_state[2];
  logic [CNT_W-1:0]  o_g0   [2];
  logic [CNT_W-1:0]  o_g1   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state per DUT. Index 0 is MAX_STARVE=4 and index 1 is MAX_STARVE=0.
  logic [DATA_W-1:0] fq [4][$];
  int                m_st [2];
  int                m_sv [2];
  int                m_g0 [2];
  int                m_g1 [2];
  logic [DATA_W-1:0] m_dat[2];
  bit                m_val[2];
  bit                glog [2][$];

  dest_pop_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus4 ();
  dest_pop_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus0 ();

  dest_pop_arbiter #(.DATA_W(DATA_W), .MAX_STARVE(4), .CNT_W(CNT_W)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  dest_pop_arbiter #(.DATA_W(DATA_W), .MAX_STARVE(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  assign bus4.arb_en = en;           assign bus0.arb_en = en;
  assign bus4.out_almost_full = af;  assign bus0.out_almost_full = af;
  assign bus4.fifo0_empty = emp[0][0];  assign bus4.fifo1_empty = emp[0][1];
  assign bus0.fifo0_empty = emp[1][0];  assign bus0.fifo1_empty = emp[1][1];
  assign bus4.datain_dest0 = hd[0][0];  assign bus4.datain_dest1 = hd[0][1];
  assign bus0.datain_dest0 = hd[1][0];  assign bus0.datain_dest1 = hd[1][1];

  assign o_pop0[0]  = bus4.pop0;          assign o_pop0[1]  = bus0.pop0;
  assign o_pop1[0]  = bus4.pop1;          assign o_pop1[1]  = bus0.pop1;
  assign o_valid[0] = bus4.validoutdest;  assign o_valid[1] = bus0.validoutdest;
  assign o_data[0]  = bus4.dataout_dest;  assign o_data[1]  = bus0.dataout_dest;
  assign o_state[0] = bus4.arb_state;     assign o_state[1] = bus0.arb_state;
  assign o_g0[0]    = bus4.gnt0_cnt;      assign o_g0[1]    = bus0.gnt0_cnt;
  assign o_g1[0]    = bus4.gnt1_cnt;      assign o_g1[1]    = bus0.gnt1_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push2(input int f, input logic [DATA_W-1:0] v);
    fq[f].push_back(v);
    fq[2 + f].push_back(v);
  endtask

  task automatic flush_all();
    for (int i = 0; i < 4; i++) fq[i].delete();
  endtask

  // Run one clock cycle. Check the registered outputs and the combinational pops, then advance the model.
  task automatic step(input bit e, input bit a, input bit r, input bit chk = 1'b1);
    bit                p0 [2];
    bit                p1 [2];
    bit                ne1[2];
    logic [DATA_W-1:0] h0 [2];
    logic [DATA_W-1:0] h1 [2];
    bit                ne0, g0, g1, can;
    int                ms;
    @(negedge clk);
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("arb_state[%0d]", k), 32'(o_state[k]), 32'(m_st[k]));
        check($sformatf("validoutdest[%0d]", k), 32'(o_valid[k]), 32'(m_val[k]));
        check($sformatf("dataout_dest[%0d]", k), 32'(o_data[k]), 32'(m_dat[k]));
        check($sformatf("gnt0_cnt[%0d]", k), 32'(o_g0[k]), 32'(m_g0[k]));
        check($sformatf("gnt1_cnt[%0d]", k), 32'(o_g1[k]), 32'(m_g1[k]));
      end
    end
    en = e; af = a; reset = r;
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 2; f++) begin
        emp[k][f] = (fq[k*2+f].size() == 0);
        hd[k][f]  = (fq[k*2+f].size() != 0) ? fq[k*2+f][0] : DATA_W'($urandom);
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      ms     = (k == 0) ? 4 : 0;
      ne0    = (fq[k*2].size() != 0);
      ne1[k] = (fq[k*2+1].size() != 0);
      h0[k]  = hd[k][0];
      h1[k]  = hd[k][1];
      if (ne0 && ne1[k]) begin
        g1 = (ms != 0) && (m_sv[k] == ms);
        g0 = !g1;
      end else begin
        g0 = ne0;
        g1 = ne1[k];
      end
      can   = (m_st[k] == 1) && e && !a && !r;
      p0[k] = g0 && can;
      p1[k] = g1 && can;
      check($sformatf("pop0[%0d]", k), 32'(o_pop0[k]), 32'(p0[k]));
      check($sformatf("pop1[%0d]", k), 32'(o_pop1[k]), 32'(p1[k]));
      if (o_pop0[k] || o_pop1[k]) glog[k].push_back(o_pop1[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_st[k] = 0; m_sv[k] = 0; m_g0[k] = 0; m_g1[k] = 0;
        m_dat[k] = '0; m_val[k] = 1'b0;
      end else begin
        if (!e)               m_st[k] = 0;
        else if (m_st[k] == 0) m_st[k] = 1;
        else                  m_st[k] = a ? 2 : 1;
        if (!ne1[k] || p1[k]) m_sv[k] = 0;
        else if (p0[k])       m_sv[k] = m_sv[k] + 1;
        m_dat[k] = p1[k] ? h1[k] : (p0[k] ? h0[k] : '0);
        m_val[k] = p0[k] || p1[k];
        if (p0[k] && m_g0[k] < CNT_MAX) m_g0[k]++;
        if (p1[k] && m_g1[k] < CNT_MAX) m_g1[k]++;
      end
      if (p0[k]) void'(fq[k*2].pop_front());
      if (p1[k]) void'(fq[k*2+1].pop_front());
    end
  endtask

  initial begin
    en = 1'b0; af = 1'b0; reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sv[k] = 0; m_g0[k] = 0; m_g1[k] = 0; m_dat[k] = '0; m_val[k] = 1'b0;
      for (int f = 0; f < 2; f++) begin emp[k][f] = 1'b1; hd[k][f] = '0; end
    end

    // Reset held for two cycles with arb_en=1 and both FIFOs non-empty.
    push2(0, 10'h3C3); push2(1, 10'h2B2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    #1;
    check("rst_state", 32'(o_state[0]), 32'd0);
    check("rst_valid", 32'(o_valid[0]), 32'd0);
    check("rst_data",  32'(o_data[0]),  32'd0);

    // fifo0 holds 0x0A1 and 0x0A2, and fifo1 is empty.
    flush_all();
    push2(0, 10'h0A1); push2(0, 10'h0A2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("seq_word1",  32'(o_data[0]),  32'h0A1);
    check("seq_valid1", 32'(o_valid[0]), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("seq_word2",  32'(o_data[0]),  32'h0A2);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("seq_valid_end", 32'(o_valid[0]), 32'd0);
    check("seq_gnt0",      32'(o_g0[0]),    32'd2);

    // Both FIFOs stay non-empty. Expect the grant pattern 0,0,0,0,1 for MAX_STARVE=4 and only dest0 for MAX_STARVE=0.
    for (int i = 0; i < 12; i++) begin
      push2(0, DATA_W'(10'h100 + i));
      push2(1, DATA_W'(10'h200 + i));
    end
    glog[0].delete(); glog[1].delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    check("starve_npops4", 32'(glog[0].size()), 32'd10);
    check("starve_npops0", 32'(glog[1].size()), 32'd10);
    for (int i = 0; i < 10 && i < glog[0].size(); i++)
      check($sformatf("starve_pat4[%0d]", i), 32'(glog[0][i]), 32'((i % 5) == 4));
    for (int i = 0; i < 10 && i < glog[1].size(); i++)
      check($sformatf("starve_pat0[%0d]", i), 32'(glog[1][i]), 32'd0);
    #1;
    check("fixed_prio_gnt1", 32'(o_g1[1]), 32'd0);

    // Backpressure for three cycles during streaming.
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("afull_state_stall", 32'(o_state[0]), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    #1;
    check("afull_valid_drain", 32'(o_valid[0]), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #1;
    check("afull_state_run", 32'(o_state[0]), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // arb_en is dropped while both FIFOs are non-empty, then enabled again.
    step(1'b0, 1'b0, 1'b0);
    #1;
    check("en_drop_state", 32'(o_state[0]), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // A pop1 of 0x155 is followed by a synchronous reset.
    flush_all();
    push2(1, 10'h155);
    step(1'b1, 1'b0, 1'b0);
    push2(0, 10'h0AA);
    step(1'b1, 1'b0, 1'b1);
    #1;
    check("rst155_valid", 32'(o_valid[0]), 32'd0);
    check("rst155_data",  32'(o_data[0]),  32'd0);
    check("rst155_gnt0",  32'(o_g0[0]),    32'd0);
    check("rst155_gnt1",  32'(o_g1[0]),    32'd0);
    check("rst155_state", 32'(o_state[0]), 32'd0);

    // Randomized traffic, backpressure, enable and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      bit e, a, r;
      for (int f = 0; f < 2; f++) begin
        if ($urandom_range(0, 99) < 55) begin
          logic [DATA_W-1:0] v;
          v = DATA_W'($urandom);
          if (fq[f].size() < 8)     fq[f].push_back(v);
          if (fq[2 + f].size() < 8) fq[2 + f].push_back(v);
        end
      end
      e = ($urandom_range(0, 99) < 95);
      a = ($urandom_range(0, 99) < 20);
      r = ($urandom_range(0, 299) == 0);
      step(e, a, r);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
